floor_call_panel: RTL and testbench

- Request initiator for the elevator FSM. Debounces per-floor call buttons, latches pending calls, and lights the call lamps.
- Issues each pending call once on the controller's floor_request/request_valid interface, using round-robin order.
- Clears a call when the car reports door-open at that floor. Sits between the button I/O and the elevator controller.

---
 rtl/floor_call_panel.sv | 155 +++++++++++++++
 tb/tb_floor_call_panel.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_call_panel.sv
// Call-button front end for the elevator controller: sync + debounce per floor, pending-call latch,
// round-robin one-shot issue of calls. Optional re-issue timeout when PANEL_RESEND_EN is defined.

module floor_call_debounce #(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             s1, s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module floor_call_panel #(
   parameter int NUM_FLOORS      = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int GAP_CYCLES      = 2,
   parameter int RESEND_CYCLES   = 64,
   localparam int FLOOR_W        = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] call_btn,
   input  logic [FLOOR_W-1:0]    car_floor,
   input  logic                  car_door_open,
   output logic [FLOOR_W-1:0]    floor_request,
   output logic                  request_valid,
   output logic [NUM_FLOORS-1:0] call_lamp
);
   localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t                state, state_nxt;
   logic [NUM_FLOORS-1:0] db, db_q, press, clr, pending, sent, avail, set_sent;
   logic [FLOOR_W-1:0]    rr, sel;
   logic [GAP_W-1:0]      gap_cnt;
   logic                  resend_fire;

   genvar f;
   generate
      for (f = 0; f < NUM_FLOORS; f++) begin : g_lane
         floor_call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .btn   (call_btn[f]),
            .level (db[f])
         );
         // Out-of-range car_floor values never match any lane, so they clear nothing.
         assign clr[f]      = car_door_open && (car_floor == FLOOR_W'(f));
         assign set_sent[f] = (state == ISSUE) && (floor_request == FLOOR_W'(f));
      end
   endgenerate

   assign press     = db & ~db_q;
   assign avail     = pending & ~sent;
   assign call_lamp = pending;

   // First available floor at or above rr, wrapping.
   always_comb begin
      logic hit;
      hit = 1'b0;
      sel = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (!hit && avail[(int'(rr) + i) % NUM_FLOORS]) begin
            hit = 1'b1;
            sel = FLOOR_W'((int'(rr) + i) % NUM_FLOORS);
         end
      end
   end

`ifdef PANEL_RESEND_EN
   localparam int RS_W = $clog2(RESEND_CYCLES + 1);
   logic [RS_W-1:0] rs_cnt;
   logic            outstanding;

   assign outstanding = |(pending & sent);
   assign resend_fire = outstanding && !car_door_open && (rs_cnt == RS_W'(RESEND_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                     rs_cnt <= '0;
      else if (!outstanding || car_door_open || resend_fire) rs_cnt <= '0;
      else                                           rs_cnt <= rs_cnt + 1'b1;
   end
`else
   assign resend_fire = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|avail) state_nxt = ISSUE;
         ISSUE:   state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:     if (gap_cnt == GAP_W'(GAP_LAST)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      request_valid = (state == ISSUE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q          <= '0;
         pending       <= '0;
         sent          <= '0;
         rr            <= '0;
         gap_cnt       <= '0;
         floor_request <= '0;
      end else begin
         db_q    <= db;
         // Clear dominates a same-cycle press: the car is already servicing that floor.
         pending <= (pending | press) & ~clr;
         if (resend_fire) sent <= set_sent & ~clr;
         else             sent <= (sent | set_sent) & ~clr;
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
         if (state == IDLE && |avail) floor_request <= sel;
         if (state == ISSUE) begin
            if (floor_request == FLOOR_W'(NUM_FLOORS - 1)) rr <= '0;
            else                                           rr <= floor_request + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_floor_call_panel.sv
// Scoreboard bench for floor_call_panel: expected floors are queued at stimulus time and
// popped by a monitor on every request_valid strobe.

module tb_floor_call_panel;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] call_btn;
   logic [1:0] car_floor;
   logic       car_door_open;
   logic [1:0] floor_request;
   logic       request_valid;
   logic [3:0] call_lamp;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int cyc    = 0;
   int exp_q[$];
   int strobe_t[$];
   int mon_exp;
   logic prev_valid = 1'b0;

   floor_call_panel #(
      .NUM_FLOORS(4), .DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .RESEND_CYCLES(16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .call_btn      (call_btn),
      .car_floor     (car_floor),
      .car_door_open (car_door_open),
      .floor_request (floor_request),
      .request_valid (request_valid),
      .call_lamp     (call_lamp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (request_valid) begin
            pulses++;
            strobe_t.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe floor=%0d (none expected)", floor_request);
            end else begin
               mon_exp = exp_q.pop_front();
               if (int'(floor_request) !== mon_exp) begin
                  errors++;
                  $display("FAIL strobe_floor got=%0d exp=%0d", floor_request, mon_exp);
               end
            end
            checks++;
            if (prev_valid) begin
               errors++;
               $display("FAIL back_to_back got=1 exp=0");
            end
         end
         prev_valid = request_valid;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pulses(input int tgt, input int budget, input string name);
      int n = 0;
      while (pulses < tgt && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (pulses < tgt) begin
         errors++;
         $display("FAIL %s_timeout pulses=%0d exp=%0d", name, pulses, tgt);
      end
   endtask

   task automatic door(input int fl);
      car_floor     = 2'(fl);
      car_door_open = 1'b1;
      tick(1);
      car_door_open = 1'b0;
   endtask

   task automatic press(input logic [3:0] m);
      call_btn = m;
      tick(12);
      call_btn = 4'b0;
      tick(10);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      reset = 1'b1; call_btn = 4'b0; car_floor = 2'd0; car_door_open = 1'b0;
      tick(3);
      checks += 3;
      if (request_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", request_valid); end
      if (floor_request !== 2'd0) begin errors++; $display("FAIL rst_floor got=%0d exp=0", floor_request); end
      if (call_lamp !== 4'b0)     begin errors++; $display("FAIL rst_lamp got=%b exp=0000", call_lamp); end
      reset = 1'b0;
      tick(3);
      checks++;
      if (call_lamp !== 4'b0 || request_valid !== 1'b0) begin
         errors++; $display("FAIL post_rst_idle lamp=%b valid=%b exp=0000/0", call_lamp, request_valid);
      end
   endtask

   task automatic test_single();
      int p0 = pulses;
      exp_q.push_back(2);
      call_btn = 4'b0100;
      tick(1);
      tick(5);
      checks++;
      if (call_lamp !== 4'b0000) begin errors++; $display("FAIL single_lamp_e5 got=%b exp=0000", call_lamp); end
      tick(1);
      checks += 2;
      if (call_lamp !== 4'b0100) begin errors++; $display("FAIL single_lamp_e6 got=%b exp=0100", call_lamp); end
      if (request_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e6 got=%b exp=0", request_valid); end
      tick(1);
      checks++;
      if (request_valid !== 1'b1 || floor_request !== 2'd2) begin
         errors++; $display("FAIL single_valid_e7 valid=%b floor=%0d exp=1/2", request_valid, floor_request);
      end
      tick(30);
      checks++;
      if (pulses - p0 !== 1) begin errors++; $display("FAIL single_once got=%0d exp=1", pulses - p0); end
      call_btn = 4'b0;
      tick(10);
   endtask

   task automatic test_glitch();
      int p0 = pulses;
      call_btn = 4'b0010;
      tick(3);
      call_btn = 4'b0;
      tick(20);
      checks += 2;
      if (call_lamp !== 4'b0100) begin errors++; $display("FAIL glitch_lamp got=%b exp=0100", call_lamp); end
      if (pulses !== p0)         begin errors++; $display("FAIL glitch_req got=%0d exp=%0d", pulses, p0); end
   endtask

   task automatic test_round_robin();
      int t0, tgt;
      pulse_reset();
      t0 = strobe_t.size();
      tgt = pulses + 3;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
      press(4'b1011);
      wait_pulses(tgt, 60, "rr_batch");
      checks += 3;
      if (strobe_t.size() >= t0 + 3) begin
         if (strobe_t[t0+1] - strobe_t[t0] !== 4) begin
            errors++; $display("FAIL rr_space1 got=%0d exp=4", strobe_t[t0+1] - strobe_t[t0]);
         end
         if (strobe_t[t0+2] - strobe_t[t0+1] !== 4) begin
            errors++; $display("FAIL rr_space2 got=%0d exp=4", strobe_t[t0+2] - strobe_t[t0+1]);
         end
      end else begin
         errors += 2; $display("FAIL rr_space strobes=%0d exp=3", strobe_t.size() - t0);
      end
      if (call_lamp !== 4'b1011) begin errors++; $display("FAIL rr_lamp got=%b exp=1011", call_lamp); end
      door(0); door(1); door(3);
      tick(1);
      // Issue floor 1 alone so rr moves to 2, then press 0 and 3 together.
      tgt = pulses + 1;
      exp_q.push_back(1);
      press(4'b0010);
      wait_pulses(tgt, 40, "rr_floor1");
      door(1);
      tgt = pulses + 2;
      exp_q.push_back(3); exp_q.push_back(0);
      press(4'b1001);
      wait_pulses(tgt, 60, "rr_wrap");
      door(0); door(3);
      tick(1);
      checks++;
      if (call_lamp !== 4'b0000) begin errors++; $display("FAIL rr_clear got=%b exp=0000", call_lamp); end
   endtask

   task automatic test_service_clear();
      int p0 = pulses;
      int tgt;
      call_btn = 4'b1000;
      tick(1);
      tick(5);
      car_floor = 2'd3;
      car_door_open = 1'b1;
      tick(1);
      car_door_open = 1'b0;
      tick(20);
      checks += 2;
      if (call_lamp !== 4'b0000) begin errors++; $display("FAIL svc_lamp got=%b exp=0000", call_lamp); end
      if (pulses !== p0)         begin errors++; $display("FAIL svc_req got=%0d exp=%0d", pulses, p0); end
      call_btn = 4'b0;
      tick(10);
      tgt = pulses + 1;
      exp_q.push_back(1);
      press(4'b0010);
      wait_pulses(tgt, 40, "svc_floor1");
      checks++;
      if (call_lamp !== 4'b0010) begin errors++; $display("FAIL svc_lamp1 got=%b exp=0010", call_lamp); end
      door(1);
      tick(1);
      checks++;
      if (call_lamp !== 4'b0000) begin errors++; $display("FAIL svc_clear1 got=%b exp=0000", call_lamp); end
   endtask

   task automatic test_reset_mid_gap();
      int tgt;
      pulse_reset();
      tgt = pulses + 1;
      exp_q.push_back(1);
      call_btn = 4'b0110;
      wait_pulses(tgt, 40, "gap_first");
      checks += 2;
      if (call_lamp !== 4'b0110) begin errors++; $display("FAIL gap_lamp got=%b exp=0110", call_lamp); end
      if (request_valid !== 1'b0) begin errors++; $display("FAIL gap_valid got=%b exp=0", request_valid); end
      reset = 1'b1;
      #1;
      checks += 3;
      if (request_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", request_valid); end
      if (floor_request !== 2'd0) begin errors++; $display("FAIL midrst_floor got=%0d exp=0", floor_request); end
      if (call_lamp !== 4'b0)     begin errors++; $display("FAIL midrst_lamp got=%b exp=0000", call_lamp); end
      call_btn = 4'b0;
      tick(3);
      reset = 1'b0;
      tick(25);
      checks++;
      if (pulses !== tgt) begin errors++; $display("FAIL midrst_survivor got=%0d exp=%0d", pulses, tgt); end
   endtask

`ifdef PANEL_RESEND_EN
   task automatic test_resend();
      int t0, tgt, p1, d;
      pulse_reset();
      t0 = strobe_t.size();
      tgt = pulses + 2;
      exp_q.push_back(2); exp_q.push_back(2);
      press(4'b0100);
      wait_pulses(tgt, 80, "resend");
      checks++;
      d = (strobe_t.size() >= t0 + 2) ? strobe_t[t0+1] - strobe_t[t0] : -1;
      if (d < 16 || d > 20) begin errors++; $display("FAIL resend_gap got=%0d exp=16..20", d); end
      door(2);
      p1 = pulses;
      tick(40);
      checks++;
      if (pulses !== p1) begin errors++; $display("FAIL resend_stop got=%0d exp=%0d", pulses, p1); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_round_robin();
      test_service_clear();
      test_reset_mid_gap();
`ifdef PANEL_RESEND_EN
      test_resend();
`endif
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
